hazard_ctrl_mc: RTL and testbench
=================================

Name: hazard_ctrl_mc

Overview:
- Parametrised pipeline hazard controller for the 5-stage MIPS core. Successor to the single-cycle load-use detector.
- Adds configurable load-use stall depth, branch-in-ID operand hazards, data-memory wait freezing, and a memory timeout flag.
- Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Drives their write enables and bubble inserts.

Parameters:
- REG_AW, 5, register address width
- LOAD_STALL, 1, bubbles inserted per load-use hazard (1..15)
- IGNORE_ZERO, 1, when 1, register address 0 never causes a hazard
- MEM_TIMEOUT, 255, maximum consecutive wait cycles before the error flag is raised (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- id_ex_mem_read  in  1  instruction in EX is a load
- id_ex_reg_write  in  1  instruction in EX writes a register
- id_ex_rd  in  REG_AW  destination register of EX instruction (after RegDst mux)
- ex_mem_mem_read  in  1  instruction in MEM is a load
- ex_mem_rd  in  REG_AW  destination register of MEM instruction
- if_id_rs  in  REG_AW  rs of ID instruction
- if_id_rt  in  REG_AW  rt of ID instruction
- if_id_uses_rt  in  1  ID instruction reads rt
- if_id_branch  in  1  ID instruction is a branch compared in ID
- mem_req  in  1  MEM stage has an active data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID write enable
- id_ex_write  out  1  ID/EX write enable
- ex_mem_write  out  1  EX/MEM write enable
- id_ex_bubble  out  1  load NOP into ID/EX
- mem_wb_bubble  out  1  load NOP into MEM/WB
- mem_timeout  out  1  sticky memory timeout error
- stall_cycles  out  32  total stall cycles (see Optional Feature)
- wait_cycles  out  32  total memory-wait cycles (see Optional Feature)

Behaviour:
- Reset:
  - On a clk edge with rst_n=0: state=RUN, hold counter=0, wait counter=0, mem_timeout=0, perf counters=0.
  - While rst_n=0, outputs are forced: all *_write=1, both bubbles=0.
  - Reset mid-stall or mid-wait aborts immediately. No carry-over.
- Match function: match(a,b) = (a==b) && !(IGNORE_ZERO && a==0).
- Hazard terms:
  - lu = id_ex_mem_read && (match(id_ex_rd,if_id_rs) || (if_id_uses_rt && match(id_ex_rd,if_id_rt))).
  - br = if_id_branch && ((id_ex_reg_write && id_ex_rd hits rs/rt) || (ex_mem_mem_read && ex_mem_rd hits rs/rt)), using the same rt qualification as lu.
- Freeze: mw = mem_req && !mem_ready.
- Outputs are combinational from state and inputs. Priority is mw > HOLD > lu > br.
  - mw: pc_write, if_id_write, id_ex_write, ex_mem_write = 0; mem_wb_bubble=1; id_ex_bubble=0.
  - Stall (HOLD state, lu or br): pc_write=0, if_id_write=0, id_ex_bubble=1. All other writes 1, mem_wb_bubble=0.
  - Otherwise: all writes 1, both bubbles 0.
- FSM states: RUN, HOLD, WAIT.
  - RUN:
    - mw -> WAIT, recording ret=RUN.
    - Else lu with LOAD_STALL>1 -> HOLD, cnt=LOAD_STALL-1.
    - Else stay in RUN. br stalls combinationally and re-evaluates every cycle.
  - HOLD:
    - mw -> WAIT, recording ret=HOLD; cnt frozen.
    - Else cnt decrements; when cnt==1 at the edge -> RUN.
  - WAIT:
    - Wait counter increments each mw cycle, saturating at MEM_TIMEOUT.
    - Reaching MEM_TIMEOUT sets mem_timeout=1, sticky until reset.
    - First cycle with mw=0 -> ret; wait counter cleared.
  - A lu arriving while in WAIT is evaluated after the return, not during the freeze.
- Latency:
  - A load-use hazard produces exactly LOAD_STALL bubble cycles, plus any memory-wait cycles interleaved.
  - A branch hazard behind an ALU op: 1 cycle. Behind a load: 2 cycles (lu cycle, then ex_mem cycle).

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cycles increments on every cycle with pc_write=0 and mw=0.
  - wait_cycles increments on every mw cycle.
  - Both are 32-bit, wrap modulo 2^32, and clear on reset.
- Undefined: no counter registers are built; stall_cycles and wait_cycles are constant 0.

Test Plan:
- LOAD_STALL=1, EX lw $8, ID add $9,$8,$3 -> one cycle: pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle all normal.
- LOAD_STALL=3, same hazard -> exactly 3 bubble cycles. Inject mem_req=1/mem_ready=0 for 2 cycles mid-hold -> full freeze for 2 cycles, then the remaining bubbles resume; 5 stall cycles total.
- ID beq $4,$5 with EX add $4 -> 1 stall. With EX lw $5 -> 2 consecutive stalls. rs=rt=0, EX rd=0, IGNORE_ZERO=1 -> no stall.
- MEM_TIMEOUT=4, mem_ready held 0 for 6 cycles -> mem_timeout rises after the 4th wait cycle and stays 1 after mem_ready=1, until rst_n=0.
- rst_n=0 for one edge during HOLD -> next cycle state RUN, all writes 1, counters 0.
- HAZARD_PERF_CNT_EN defined, 3 load-use stalls plus 2 wait cycles -> stall_cycles=3, wait_cycles=2. Undefined -> both read 0.

Source files
------------

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller for the 5-stage MIPS core.
// Detects load-use and branch-in-ID operand hazards, freezes the pipe on
// data-memory waits, and flags memory timeouts.
// Optional macro HAZARD_PERF_CNT_EN builds the stall/wait performance counters;
// without it stall_cycles and wait_cycles are tied to zero.
module hazard_ctrl_mc #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned LOAD_STALL  = 1,
    parameter int unsigned IGNORE_ZERO = 1,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_ex_mem_read,
    input  logic              id_ex_reg_write,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              ex_mem_mem_read,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic [REG_AW-1:0] if_id_rs,
    input  logic [REG_AW-1:0] if_id_rt,
    input  logic              if_id_uses_rt,
    input  logic              if_id_branch,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_write,
    output logic              ex_mem_write,
    output logic              id_ex_bubble,
    output logic              mem_wb_bubble,
    output logic              mem_timeout,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       wait_cycles
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  HOLD_INIT = CNT_W'(LOAD_STALL - 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                ret_hold_q, ret_hold_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                timeout_q, timeout_d;

    logic ex_hit, mem_hit, lu_hzd, br_hzd, mw;
    logic stall, freeze, stall_ev;
    state_e eff_state;

    // Register-address compare; address zero optionally never matches.
    function automatic logic match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
        return (a == b) && !((IGNORE_ZERO != 0) && (a == '0));
    endfunction

    // Hazard terms against the ID-stage operands.
    assign ex_hit  = match(id_ex_rd, if_id_rs)  || (if_id_uses_rt && match(id_ex_rd, if_id_rt));
    assign mem_hit = match(ex_mem_rd, if_id_rs) || (if_id_uses_rt && match(ex_mem_rd, if_id_rt));
    assign lu_hzd  = id_ex_mem_read && ex_hit;
    assign br_hzd  = if_id_branch && ((id_ex_reg_write && ex_hit) || (ex_mem_mem_read && mem_hit));
    assign mw      = mem_req && !mem_ready;

    // State register and wait/hold bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            ret_hold_q <= 1'b0;
            cnt_q      <= '0;
            wcnt_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_hold_q <= ret_hold_d;
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next state; the cycle a wait ends behaves as the state it returns to.
    always_comb begin
        state_d    = state_q;
        ret_hold_d = ret_hold_q;
        cnt_d      = cnt_q;
        wcnt_d     = wcnt_q;
        timeout_d  = timeout_q;
        stall      = 1'b0;
        freeze     = 1'b0;
        eff_state  = state_q;
        if (state_q == ST_WAIT) begin
            eff_state = ret_hold_q ? ST_HOLD : ST_RUN;
        end

        if (mw) begin
            freeze  = 1'b1;
            state_d = ST_WAIT;
            if (state_q != ST_WAIT) begin
                ret_hold_d = (state_q == ST_HOLD);
            end
            if (wcnt_q != WCNT_MAX) begin
                wcnt_d = WCNT_W'(wcnt_q + 1'b1);
            end
            if (wcnt_d == WCNT_MAX) begin
                timeout_d = 1'b1;
            end
        end else begin
            wcnt_d = '0;
            case (eff_state)
                ST_HOLD: begin
                    stall = 1'b1;
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = CNT_W'(cnt_q - 1'b1);
                    end
                end
                default: begin
                    stall   = lu_hzd || br_hzd;
                    state_d = ST_RUN;
                    if (lu_hzd && (LOAD_STALL > 1)) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_INIT;
                    end
                end
            endcase
        end
    end

    // Pipeline-register controls; reset forces the pass-through pattern.
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;
        if (rst_n) begin
            if (freeze) begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_write  = 1'b0;
                mem_wb_bubble = 1'b1;
            end else if (stall) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
    end

    assign mem_timeout = timeout_q;
    assign stall_ev    = stall && !mw;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;

    assign stall_cnt_d = stall_ev ? 32'(stall_cnt_q + 32'd1) : stall_cnt_q;
    assign wait_cnt_d  = mw       ? 32'(wait_cnt_q + 32'd1)  : wait_cnt_q;

    // Free-running performance counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign wait_cycles  = wait_cnt_q;
`else
    logic unused_perf;
    assign unused_perf  = stall_ev;
    assign stall_cycles = '0;
    assign wait_cycles  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench for hazard_ctrl_mc: two instances (LOAD_STALL=1 and 3,
// both MEM_TIMEOUT=4) share the stimulus; each vector names the instance it checks.
module tb_hazard_ctrl_mc;

    localparam logic [5:0] NRM = 6'b111100;
    localparam logic [5:0] STL = 6'b001110;
    localparam logic [5:0] FRZ = 6'b000001;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        int          sel;
        logic [5:0]  ctl;
        logic        to;
        logic [31:0] sc;
        logic [31:0] wc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic mr, rw, xmr, urt, brn, req, rdy;
    logic [4:0] rd, xrd, rs, rt;

    wire [5:0]  ctl1, ctl3;
    wire        to1, to3;
    wire [31:0] sc1, sc3, wc1, wc3;

    exp_t  exp_q[$];
    string name_q[$];
    bit    stim_done = 1'b0;
    int    n_tests = 0;
    int    n_fail  = 0;

    always #5 clk = ~clk;

    hazard_ctrl_mc #(.REG_AW(5), .LOAD_STALL(1), .IGNORE_ZERO(1), .MEM_TIMEOUT(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .id_ex_mem_read(mr), .id_ex_reg_write(rw), .id_ex_rd(rd),
        .ex_mem_mem_read(xmr), .ex_mem_rd(xrd),
        .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rt(urt), .if_id_branch(brn),
        .mem_req(req), .mem_ready(rdy),
        .pc_write(ctl1[5]), .if_id_write(ctl1[4]), .id_ex_write(ctl1[3]), .ex_mem_write(ctl1[2]),
        .id_ex_bubble(ctl1[1]), .mem_wb_bubble(ctl1[0]),
        .mem_timeout(to1), .stall_cycles(sc1), .wait_cycles(wc1)
    );

    hazard_ctrl_mc #(.REG_AW(5), .LOAD_STALL(3), .IGNORE_ZERO(1), .MEM_TIMEOUT(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .id_ex_mem_read(mr), .id_ex_reg_write(rw), .id_ex_rd(rd),
        .ex_mem_mem_read(xmr), .ex_mem_rd(xrd),
        .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rt(urt), .if_id_branch(brn),
        .mem_req(req), .mem_ready(rdy),
        .pc_write(ctl3[5]), .if_id_write(ctl3[4]), .id_ex_write(ctl3[3]), .ex_mem_write(ctl3[2]),
        .id_ex_bubble(ctl3[1]), .mem_wb_bubble(ctl3[0]),
        .mem_timeout(to3), .stall_cycles(sc3), .wait_cycles(wc3)
    );

    // One cycle of stimulus plus the response expected during that cycle.
    task automatic cyc(input string nm, input int sel, input logic rstn,
                       input logic imr, input logic irw, input logic [4:0] ird,
                       input logic ixmr, input logic [4:0] ixrd,
                       input logic [4:0] irs, input logic [4:0] irt, input logic iurt, input logic ibr,
                       input logic ireq, input logic irdy,
                       input logic [5:0] ctl, input logic to, input int sc, input int wc);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rstn; mr = imr; rw = irw; rd = ird; xmr = ixmr; xrd = ixrd;
        rs = irs; rt = irt; urt = iurt; brn = ibr; req = ireq; rdy = irdy;
        e.sel = sel; e.ctl = ctl; e.to = to;
        e.sc = PERF ? 32'(sc) : 32'd0;
        e.wc = PERF ? 32'(wc) : 32'd0;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Stimulus: directed vectors with hand-computed responses.
    initial begin
        rst_n = 1'b0; mr = 1'b0; rw = 1'b0; rd = '0; xmr = 1'b0; xrd = '0;
        rs = '0; rt = '0; urt = 1'b0; brn = 1'b0; req = 1'b0; rdy = 1'b0;

        // LOAD_STALL=1 instance
        cyc("rst_force",  1, 0, 1, 1, 8, 0, 0, 8, 3, 1, 0, 0, 0, NRM, 0, 0, 0);
        cyc("lu_rs",      1, 1, 1, 1, 8, 0, 0, 8, 3, 1, 0, 0, 0, STL, 0, 0, 0);
        cyc("lu_release", 1, 1, 0, 0, 0, 1, 8, 8, 3, 1, 0, 0, 0, NRM, 0, 1, 0);
        cyc("rt_unused",  1, 1, 1, 1, 8, 0, 0, 3, 8, 0, 0, 0, 0, NRM, 0, 1, 0);
        cyc("lu_rt",      1, 1, 1, 1, 8, 0, 0, 3, 8, 1, 0, 0, 0, STL, 0, 1, 0);
        cyc("br_alu",     1, 1, 0, 1, 4, 0, 0, 4, 5, 1, 1, 0, 0, STL, 0, 2, 0);
        cyc("br_alu_fwd", 1, 1, 0, 0, 0, 0, 4, 4, 5, 1, 1, 0, 0, NRM, 0, 3, 0);
        cyc("br_ld_1",    1, 1, 1, 1, 5, 0, 0, 4, 5, 1, 1, 0, 0, STL, 0, 3, 0);
        cyc("br_ld_2",    1, 1, 0, 0, 0, 1, 5, 4, 5, 1, 1, 0, 0, STL, 0, 4, 0);
        cyc("br_ld_3",    1, 1, 0, 0, 0, 0, 0, 4, 5, 1, 1, 0, 0, NRM, 0, 5, 0);
        cyc("zero_reg",   1, 1, 1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0, NRM, 0, 5, 0);
        cyc("no_branch",  1, 1, 0, 1, 4, 1, 4, 4, 5, 1, 0, 0, 0, NRM, 0, 5, 0);
        for (int w = 1; w <= 6; w++) begin
            cyc($sformatf("tmo_w%0d", w), 1, 1, logic'(w == 1), 0, 8, 0, 0, 8, 3, 1, 0, 1, 0,
                FRZ, logic'(w >= 5), 5, w - 1);
        end
        cyc("tmo_ready",  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NRM, 1, 5, 6);
        cyc("tmo_sticky", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 1, 5, 6);
        cyc("rst_clr",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 1, 5, 6);
        cyc("post_rst",   1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0, 0);

        // LOAD_STALL=3 instance
        cyc("rst3",       3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0, 0);
        cyc("ls3_b1",     3, 1, 1, 1, 8, 0, 0, 8, 3, 1, 0, 0, 0, STL, 0, 0, 0);
        cyc("ls3_b2",     3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, STL, 0, 1, 0);
        cyc("ls3_frz1",   3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 2, 0);
        cyc("ls3_frz2",   3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 2, 1);
        cyc("ls3_b3",     3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, STL, 0, 2, 2);
        cyc("ls3_done",   3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 3, 2);
        cyc("wlu_frz",    3, 1, 1, 1, 8, 0, 0, 8, 3, 1, 0, 1, 0, FRZ, 0, 3, 2);
        cyc("wlu_ret",    3, 1, 1, 1, 8, 0, 0, 8, 3, 1, 0, 0, 0, STL, 0, 3, 3);
        cyc("wlu_b2",     3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, STL, 0, 4, 3);
        cyc("wlu_b3",     3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, STL, 0, 5, 3);
        cyc("wlu_done",   3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 6, 3);
        cyc("rh_lu",      3, 1, 1, 1, 8, 0, 0, 8, 3, 1, 0, 0, 0, STL, 0, 6, 3);
        cyc("rh_rst",     3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 7, 3);
        cyc("rh_post",    3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0, 0);
        stim_done = 1'b1;
    end

    // Monitor: pops one expectation per cycle and compares mid-cycle.
    initial begin : monitor
        exp_t        e;
        string       nm;
        logic [5:0]  a_ctl;
        logic        a_to;
        logic [31:0] a_sc, a_wc;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a_ctl = (e.sel == 1) ? ctl1 : ctl3;
                a_to  = (e.sel == 1) ? to1  : to3;
                a_sc  = (e.sel == 1) ? sc1  : sc3;
                a_wc  = (e.sel == 1) ? wc1  : wc3;
                n_tests++;
                if (a_ctl !== e.ctl || a_to !== e.to || a_sc !== e.sc || a_wc !== e.wc) begin
                    n_fail++;
                    $display("FAIL %s: got ctl=%b to=%b sc=%0d wc=%0d, want ctl=%b to=%b sc=%0d wc=%0d",
                             nm, a_ctl, a_to, a_sc, a_wc, e.ctl, e.to, e.sc, e.wc);
                end
            end else if (stim_done) begin
                break;
            end
        end
        if (!stim_done || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

endmodule
